glyph_bitmap_memory: RTL and testbench
======================================

// Module: glyph_bitmap_memory
// PURPOSE
//  Multi-glyph 1-bit bitmap store for the character pipeline of the VGA GPU. Holds NUM_GLYPHS
//  glyphs of GLYPH_W x GLYPH_H pixels, all writable. Has a 2-stage pipelined pixel read port
//  for the scan-out path and a per-pixel write port for the Arduino command path.
//  A restore sequencer reloads the default pattern one row per cycle, without a full reset.
// PARAMETERS
//  GLYPH_W        4                    pixels per glyph row (>=2)
//  GLYPH_H        5                    rows per glyph (>=2)
//  NUM_GLYPHS     4                    glyphs stored (>=1)
//  RESET_PATTERN  20'hA5A5A            GLYPH_W*GLYPH_H bits, default for every glyph; bit index = y*GLYPH_W + x
//  (derived) XW=max(1,clog2(GLYPH_W)), YW=max(1,clog2(GLYPH_H)), GW=max(1,clog2(NUM_GLYPHS))
// PORTS
//  clock     in   1   single clock, all logic on posedge
//  rst       in   1   synchronous, active-high reset
//  rd_en     in   1   read request this cycle
//  rd_glyph  in   GW  glyph index for read
//  rd_x      in   XW  column for read
//  rd_y      in   YW  row for read
//  rd_data   out  1   pixel value, valid when rd_valid=1
//  rd_valid  out  1   read result strobe
//  wr_en     in   1   write request this cycle
//  wr_glyph  in   GW  glyph index for write
//  wr_x      in   XW  column for write
//  wr_y      in   YW  row for write
//  wr_data   in   1   pixel value to write
//  restore   in   1   pulse: reload RESET_PATTERN into all glyphs
//  busy      out  1   restore sequence in progress
// BEHAVIOUR
//  - Reset (rst=1 at posedge): every glyph row <= its RESET_PATTERN slice, in the same cycle.
//    Also rd_data=0, rd_valid=0, busy=0, pipeline cleared, sequencer IDLE.
//    Reset mid-restore aborts the sequence. The array still ends fully restored.
//  - Storage: NUM_GLYPHS*GLYPH_H rows of GLYPH_W bits. Row address = glyph*GLYPH_H + y.
//  - Read: latency 2, fully pipelined, one request per cycle accepted.
//    S1 (edge N): latch the addressed row, rd_x, and valid. S2 (edge N+1): column mux -> rd_data.
//    rd_valid=1 for exactly one cycle per accepted rd_en.
//  - Read out-of-range (rd_glyph>=NUM_GLYPHS, rd_y>=GLYPH_H or rd_x>=GLYPH_W):
//    rd_valid=1, rd_data=0 (zero padding).
//  - rd_data holds its last value while rd_valid=0.
//  - Write: takes effect at the edge where wr_en=1. Out-of-range coordinates: dropped, no state change.
//  - Read and write to the same pixel in the same cycle: read returns the OLD value.
//    A read issued the next cycle returns the new value.
//  - Restore FSM, IDLE -> RUN -> IDLE:
//    IDLE: restore=1 -> RUN, row counter=0, busy=1 from the next cycle.
//    RUN: each cycle, row[counter] <= pattern slice for (counter mod GLYPH_H); counter++.
//    After the last row (NUM_GLYPHS*GLYPH_H-1) is written -> IDLE, busy=0.
//    Duration: exactly NUM_GLYPHS*GLYPH_H cycles.
//  - restore while busy: ignored, the sequence is not restarted.
//  - wr_en while busy (including the cycle restore is sampled): write dropped.
//  - Reads while busy: served normally and return current array contents (mixed old/restored).
// STRUCTURE
//  - glyph_mem_pkg: clog2-with-floor-1 function and default constants (GLYPH_W/H, NUM_GLYPHS,
//    RESET_PATTERN).
//  - Sub-module glyph_restore_seq: IDLE/RUN FSM plus row counter.
//    Outputs busy, row_we, row_addr, row_sel_y (counter mod GLYPH_H).
//  - Top level: row array, write decode, 2-stage read pipeline.
// TESTING
//  1 Reset, then read glyph0 (x,y) = (0,0),(1,0),(0,1) -> rd_data 0,1,1, each 2 cycles after rd_en.
//    Back-to-back reads give rd_valid high 3 consecutive cycles.
//  2 Write glyph2 (3,4)=0 (default 1), then read it next cycle -> 0.
//    Glyph1 (3,4) still reads 1.
//  3 Same cycle: wr glyph0 (1,0)=0 and rd glyph0 (1,0) -> 1. Repeat the read -> 0.
//  4 Read glyph 3 y=5, and write glyph 3 y=5 -> rd_data=0, rd_valid=1; array unchanged.
//    Same for x>=GLYPH_W with a non-power-of-2 GLYPH_W=3 build.
//  5 Corrupt 4 pixels, pulse restore -> busy high exactly 20 cycles.
//    wr_en during busy has no effect; a second restore pulse mid-run does not extend busy.
//    Afterwards all pixels match RESET_PATTERN.
//  6 Pulse restore, assert rst at cycle 7 -> busy=0 and rd_valid=0 the next cycle.
//    All pixels equal the default.

Source files
------------

// File: rtl/glyph_mem_pkg.sv
// Shared sizing helper, default geometry and sequencer state type for the glyph bitmap store.
package glyph_mem_pkg;

   // Bits needed to address 'value' entries, but never fewer than one.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits = bits + 1;
      return (bits < 1) ? 1 : bits;
   endfunction

   localparam int          DEF_GLYPH_W       = 4;
   localparam int          DEF_GLYPH_H       = 5;
   localparam int          DEF_NUM_GLYPHS    = 4;
   localparam logic [19:0] DEF_RESET_PATTERN = 20'hA5A5A;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/glyph_restore_seq.sv
// Restore sequencer: walks every row once, emitting one default-pattern row write per cycle.
module glyph_restore_seq
   import glyph_mem_pkg::*;
#(
   parameter int GLYPH_H  = DEF_GLYPH_H,
   parameter int NUM_ROWS = DEF_GLYPH_H * DEF_NUM_GLYPHS,
   parameter int AW       = clog2_min1(NUM_ROWS),
   parameter int YW       = clog2_min1(GLYPH_H)
) (
   input  logic           clock,
   input  logic           rst,
   input  logic           restore,
   output seq_state_e     state,
   output logic           busy,
   output logic           row_we,
   output logic [AW-1:0]  row_addr,
   output logic [YW-1:0]  row_sel_y
);

   localparam logic [AW-1:0] LAST_ROW = AW'(NUM_ROWS - 1);
   localparam logic [YW-1:0] LAST_Y   = YW'(GLYPH_H - 1);

   seq_state_e      state_next;
   logic [AW-1:0]   row_cnt;
   logic [AW-1:0]   row_cnt_next;
   logic [YW-1:0]   y_cnt;
   logic [YW-1:0]   y_cnt_next;

   always_ff @(posedge clock) begin
      if (rst) begin
         state   <= SEQ_IDLE;
         row_cnt <= '0;
         y_cnt   <= '0;
      end else begin
         state   <= state_next;
         row_cnt <= row_cnt_next;
         y_cnt   <= y_cnt_next;
      end
   end

   // y_cnt tracks row_cnt mod GLYPH_H incrementally so no divider is needed.
   always_comb begin
      state_next   = state;
      row_cnt_next = row_cnt;
      y_cnt_next   = y_cnt;
      case (state)
         SEQ_IDLE: begin
            if (restore) begin
               state_next   = SEQ_RUN;
               row_cnt_next = '0;
               y_cnt_next   = '0;
            end
         end
         SEQ_RUN: begin
            if (row_cnt == LAST_ROW) begin
               state_next   = SEQ_IDLE;
               row_cnt_next = '0;
               y_cnt_next   = '0;
            end else begin
               row_cnt_next = row_cnt + AW'(1);
               y_cnt_next   = (y_cnt == LAST_Y) ? '0 : y_cnt + YW'(1);
            end
         end
         default: state_next = SEQ_IDLE;
      endcase
   end

   assign busy      = (state == SEQ_RUN);
   assign row_we    = (state == SEQ_RUN);
   assign row_addr  = row_cnt;
   assign row_sel_y = y_cnt;

endmodule

// File: rtl/glyph_bitmap_memory.sv
// Multi-glyph 1-bit bitmap store: pixel write port, 2-stage pipelined pixel read port,
// and a row-at-a-time restore of the default pattern.
module glyph_bitmap_memory
   import glyph_mem_pkg::*;
#(
   parameter int                             GLYPH_W       = DEF_GLYPH_W,
   parameter int                             GLYPH_H       = DEF_GLYPH_H,
   parameter int                             NUM_GLYPHS    = DEF_NUM_GLYPHS,
   parameter logic [GLYPH_W*GLYPH_H-1:0]     RESET_PATTERN = DEF_RESET_PATTERN,
   localparam int                            XW            = clog2_min1(GLYPH_W),
   localparam int                            YW            = clog2_min1(GLYPH_H),
   localparam int                            GW            = clog2_min1(NUM_GLYPHS)
) (
   input  logic           clock,
   input  logic           rst,
   input  logic           rd_en,
   input  logic [GW-1:0]  rd_glyph,
   input  logic [XW-1:0]  rd_x,
   input  logic [YW-1:0]  rd_y,
   output logic           rd_data,
   output logic           rd_valid,
   input  logic           wr_en,
   input  logic [GW-1:0]  wr_glyph,
   input  logic [XW-1:0]  wr_x,
   input  logic [YW-1:0]  wr_y,
   input  logic           wr_data,
   input  logic           restore,
   output logic           busy
);

   localparam int NUM_ROWS = NUM_GLYPHS * GLYPH_H;
   localparam int AW       = clog2_min1(NUM_ROWS);

   logic [GLYPH_W-1:0] rows         [NUM_ROWS];
   logic [GLYPH_W-1:0] default_rows [GLYPH_H];

   seq_state_e         seq_state;
   logic               row_we;
   logic [AW-1:0]      row_addr;
   logic [YW-1:0]      row_sel_y;

   logic               rd_hit;
   logic               wr_hit;
   logic               wr_ok;
   logic [AW-1:0]      rd_row;
   logic [AW-1:0]      wr_row;

   logic               s1_valid;
   logic               s1_hit;
   logic [GLYPH_W-1:0] s1_row;
   logic [XW-1:0]      s1_x;

   for (genvar gy = 0; gy < GLYPH_H; gy++) begin : g_default
      assign default_rows[gy] = RESET_PATTERN[gy*GLYPH_W +: GLYPH_W];
   end

   glyph_restore_seq #(
      .GLYPH_H  (GLYPH_H),
      .NUM_ROWS (NUM_ROWS),
      .AW       (AW),
      .YW       (YW)
   ) u_restore_seq (
      .clock     (clock),
      .rst       (rst),
      .restore   (restore),
      .state     (seq_state),
      .busy      (busy),
      .row_we    (row_we),
      .row_addr  (row_addr),
      .row_sel_y (row_sel_y)
   );

   assign rd_hit = (int'(rd_glyph) < NUM_GLYPHS) && (int'(rd_y) < GLYPH_H) && (int'(rd_x) < GLYPH_W);
   assign wr_hit = (int'(wr_glyph) < NUM_GLYPHS) && (int'(wr_y) < GLYPH_H) && (int'(wr_x) < GLYPH_W);
   assign rd_row = AW'(int'(rd_glyph) * GLYPH_H + int'(rd_y));
   assign wr_row = AW'(int'(wr_glyph) * GLYPH_H + int'(wr_y));

   // Host writes are locked out for the whole restore, including the cycle it is accepted.
   assign wr_ok  = wr_en && wr_hit && !restore && (seq_state != SEQ_RUN);

   always_ff @(posedge clock) begin
      if (rst) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            rows[r] <= RESET_PATTERN[(r % GLYPH_H)*GLYPH_W +: GLYPH_W];
         end
      end else if (row_we) begin
         rows[row_addr] <= default_rows[row_sel_y];
      end else if (wr_ok) begin
         rows[wr_row][wr_x] <= wr_data;
      end
   end

   // Stage 1 samples the array before this edge's write lands, so a same-cycle read sees old data.
   always_ff @(posedge clock) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_row   <= '0;
         s1_x     <= '0;
         rd_valid <= 1'b0;
         rd_data  <= 1'b0;
      end else begin
         s1_valid <= rd_en;
         if (rd_en) begin
            s1_hit <= rd_hit;
            s1_row <= rd_hit ? rows[rd_row] : '0;
            s1_x   <= rd_x;
         end
         rd_valid <= s1_valid;
         if (s1_valid) begin
            rd_data <= s1_hit & s1_row[s1_x];
         end
      end
   end

endmodule

// File: tb/tb_glyph_bitmap_memory.sv
// Directed bench for glyph_bitmap_memory: default 4x5x4 build plus a 3-wide build for column range.
module tb_glyph_bitmap_memory;

   localparam logic [19:0] PAT_A = 20'hA5A5A;
   localparam logic [14:0] PAT_B = 15'h5A5A;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;

   logic       rd_en = 1'b0;
   logic [1:0] rd_glyph = '0;
   logic [1:0] rd_x = '0;
   logic [2:0] rd_y = '0;
   logic       rd_data;
   logic       rd_valid;
   logic       wr_en = 1'b0;
   logic [1:0] wr_glyph = '0;
   logic [1:0] wr_x = '0;
   logic [2:0] wr_y = '0;
   logic       wr_data = 1'b0;
   logic       restore = 1'b0;
   logic       busy;

   logic       b_rd_en = 1'b0;
   logic [1:0] b_rd_glyph = '0;
   logic [1:0] b_rd_x = '0;
   logic [2:0] b_rd_y = '0;
   logic       b_rd_data;
   logic       b_rd_valid;
   logic       b_wr_en = 1'b0;
   logic [1:0] b_wr_glyph = '0;
   logic [1:0] b_wr_x = '0;
   logic [2:0] b_wr_y = '0;
   logic       b_wr_data = 1'b0;
   logic       b_restore = 1'b0;
   logic       b_busy;

   int n_checks = 0;
   int n_fail   = 0;

   glyph_bitmap_memory dut (
      .clock(clock), .rst(rst),
      .rd_en(rd_en), .rd_glyph(rd_glyph), .rd_x(rd_x), .rd_y(rd_y),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_glyph(wr_glyph), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
      .restore(restore), .busy(busy)
   );

   glyph_bitmap_memory #(
      .GLYPH_W(3), .GLYPH_H(5), .NUM_GLYPHS(4), .RESET_PATTERN(PAT_B)
   ) dut_b (
      .clock(clock), .rst(rst),
      .rd_en(b_rd_en), .rd_glyph(b_rd_glyph), .rd_x(b_rd_x), .rd_y(b_rd_y),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .wr_en(b_wr_en), .wr_glyph(b_wr_glyph), .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_data(b_wr_data),
      .restore(b_restore), .busy(b_busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic read_a(input string tag, input int g, input int x, input int y, input logic exp);
      rd_glyph = 2'(g); rd_x = 2'(x); rd_y = 3'(y); rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      check({tag, " valid"}, 32'(rd_valid), 32'd1);
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic write_a(input int g, input int x, input int y, input logic d);
      wr_glyph = 2'(g); wr_x = 2'(x); wr_y = 3'(y); wr_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic read_b(input string tag, input int g, input int x, input int y, input logic exp);
      b_rd_glyph = 2'(g); b_rd_x = 2'(x); b_rd_y = 3'(y); b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      tick();
      check({tag, " valid"}, 32'(b_rd_valid), 32'd1);
      check(tag, 32'(b_rd_data), 32'(exp));
   endtask

   task automatic sweep_default(input string tag);
      for (int g = 0; g < 4; g++)
         for (int y = 0; y < 5; y++)
            for (int x = 0; x < 4; x++)
               read_a($sformatf("%s g%0d x%0d y%0d", tag, g, x, y), g, x, y, PAT_A[y*4 + x]);
   endtask

   int busy_cnt;

   initial begin
      // reset
      tick();
      tick();
      rst = 1'b0;
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset b busy", 32'(b_busy), 32'd0);

      // 1: back-to-back reads of glyph0 (0,0),(1,0),(0,1) -> 0,1,1
      rd_glyph = 2'd0; rd_x = 2'd0; rd_y = 3'd0; rd_en = 1'b1;
      tick();
      rd_x = 2'd1; rd_y = 3'd0;
      tick();
      check("b2b0 valid", 32'(rd_valid), 32'd1);
      check("b2b0 data", 32'(rd_data), 32'd0);
      rd_x = 2'd0; rd_y = 3'd1;
      tick();
      check("b2b1 valid", 32'(rd_valid), 32'd1);
      check("b2b1 data", 32'(rd_data), 32'd1);
      rd_en = 1'b0;
      tick();
      check("b2b2 valid", 32'(rd_valid), 32'd1);
      check("b2b2 data", 32'(rd_data), 32'd1);
      tick();
      check("b2b idle valid", 32'(rd_valid), 32'd0);
      check("b2b hold data", 32'(rd_data), 32'd1);

      // 2: write then read next cycle
      write_a(2, 3, 4, 1'b0);
      read_a("wr g2 3,4", 2, 3, 4, 1'b0);
      read_a("untouched g1 3,4", 1, 3, 4, 1'b1);

      // 3: same-cycle read/write returns old value, next read new
      wr_glyph = 2'd0; wr_x = 2'd1; wr_y = 3'd0; wr_data = 1'b0; wr_en = 1'b1;
      rd_glyph = 2'd0; rd_x = 2'd1; rd_y = 3'd0; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      tick();
      check("rw same cycle valid", 32'(rd_valid), 32'd1);
      check("rw same cycle old", 32'(rd_data), 32'd1);
      read_a("rw after new", 0, 1, 0, 1'b0);

      // 4: out-of-range reads and writes
      read_a("oob read g3 y5", 3, 0, 5, 1'b0);
      read_a("oob read g3 y7 x3", 3, 3, 7, 1'b0);
      write_a(3, 0, 5, 1'b1);
      write_a(2, 0, 5, 1'b1);
      read_a("oob write no alias g3 0,0", 3, 0, 0, 1'b0);
      read_a("oob write g3 0,4", 3, 0, 4, 1'b0);
      read_b("b oob x3", 0, 3, 0, 1'b0);
      write_b_block();
      read_b("b 2,0", 0, 2, 0, 1'b0);
      read_b("b 1,0", 0, 1, 0, 1'b1);
      read_b("b 0,1", 0, 0, 1, 1'b1);
      read_b("b oob x3 y1", 0, 3, 1, 1'b0);

      // 5: corrupt, restore, check busy length and write lockout
      write_a(0, 0, 0, 1'b1);
      write_a(1, 1, 1, 1'b1);
      write_a(2, 2, 2, 1'b1);
      write_a(3, 3, 3, 1'b1);
      read_a("corrupt g1 1,1", 1, 1, 1, 1'b1);
      restore = 1'b1;
      tick();
      restore = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_cnt++;
         if (i == 4) begin
            wr_glyph = 2'd0; wr_x = 2'd0; wr_y = 3'd1; wr_data = 1'b0; wr_en = 1'b1;
         end
         if (i == 5) wr_en = 1'b0;
         if (i == 8) restore = 1'b1;
         if (i == 9) restore = 1'b0;
         tick();
      end
      check("restore busy cycles", 32'(busy_cnt), 32'd20);
      check("restore busy done", 32'(busy), 32'd0);
      read_a("write during busy dropped", 0, 0, 1, 1'b1);
      sweep_default("restored");

      // 6: reset in the middle of a restore
      write_a(3, 3, 4, 1'b0);
      restore = 1'b1;
      tick();
      restore = 1'b0;
      check("restore2 busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      rd_glyph = 2'd0; rd_x = 2'd1; rd_y = 3'd0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort rd_valid", 32'(rd_valid), 32'd0);
      check("abort rd_data", 32'(rd_data), 32'd0);
      tick();
      check("abort busy stays low", 32'(busy), 32'd0);
      sweep_default("after abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic write_b_block();
      b_wr_glyph = 2'd0; b_wr_x = 2'd3; b_wr_y = 3'd0; b_wr_data = 1'b1; b_wr_en = 1'b1;
      tick();
      b_wr_en = 1'b0;
   endtask

endmodule
